// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - FIFO read port and output stream bundle for fifo_stream_reader
interface fifo_stream_reader_if #(
    parameter int FIFO_WIDTH = 16
);
    logic                  fifo_empty;
    logic [FIFO_WIDTH-1:0] fifo_dout;
    logic                  fifo_ren;
    logic [FIFO_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;
    logic [31:0]           beat_total;

    modport slave (
        input  fifo_empty, fifo_dout, m_ready,
        output fifo_ren, m_data, m_valid, m_last, beat_total
    );

    modport master (
        output fifo_empty, fifo_dout, m_ready,
        input  fifo_ren, m_data, m_valid, m_last, beat_total
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO drain engine with 3-entry skid buffer and burst-framed output stream
module fifo_stream_reader #(
    parameter int FIFO_WIDTH = 16,
    parameter int BURST_LEN  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_stream_reader_if.slave  bus
);
    localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);

    logic [FIFO_WIDTH-1:0] buf_q [3];
    logic [FIFO_WIDTH-1:0] buf_d [3];
    logic [1:0]            occ_q, occ_d;
    logic [1:0]            wr_idx_q, wr_idx_d;
    logic [1:0]            rd_idx_q, rd_idx_d;
    logic                  pend_q, pend_d;
    logic [15:0]           beat_idx_q, beat_idx_d;
    logic [31:0]           beat_total_q, beat_total_d;
    logic                  ren;
    logic                  valid;
    logic                  pop;

    function automatic logic [1:0] inc_mod3(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Reserve a slot for every read in flight so the buffer can never overflow.
    assign ren   = !bus.fifo_empty && (({1'b0, occ_q} + {2'b00, pend_q}) < 3'd3);
    assign valid = (occ_q != 2'd0);
    assign pop   = valid && bus.m_ready;

    always_comb begin
        buf_d        = buf_q;
        occ_d        = occ_q;
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        pend_d       = ren;
        beat_idx_d   = beat_idx_q;
        beat_total_d = beat_total_q;
        if (pend_q) begin
            buf_d[wr_idx_q] = bus.fifo_dout;
            wr_idx_d        = inc_mod3(wr_idx_q);
        end
        if (pop) begin
            rd_idx_d     = inc_mod3(rd_idx_q);
            beat_idx_d   = (beat_idx_q == LAST_IDX) ? 16'd0 : beat_idx_q + 16'd1;
            beat_total_d = beat_total_q + 32'd1;
        end
        case ({pend_q, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= '0;
            end
            occ_q        <= 2'd0;
            wr_idx_q     <= 2'd0;
            rd_idx_q     <= 2'd0;
            pend_q       <= 1'b0;
            beat_idx_q   <= 16'd0;
            beat_total_q <= 32'd0;
        end else begin
            buf_q        <= buf_d;
            occ_q        <= occ_d;
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            pend_q       <= pend_d;
            beat_idx_q   <= beat_idx_d;
            beat_total_q <= beat_total_d;
        end
    end

    assign bus.fifo_ren   = ren;
    assign bus.m_valid    = valid;
    assign bus.m_data     = buf_q[rd_idx_q];
    assign bus.m_last     = valid && (beat_idx_q == LAST_IDX);
    assign bus.beat_total = beat_total_q;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_stream_reader_if #(.FIFO_WIDTH(16)) bus ();

    fifo_stream_reader #(.FIFO_WIDTH(16), .BURST_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr;

    // FIFO model: registered read data, reset together with the DUT
    assign bus.fifo_empty = (rd_ptr == wr_ptr);
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr        <= 0;
            bus.fifo_dout <= '0;
        end else if (bus.fifo_ren) begin
            bus.fifo_dout <= mem[rd_ptr];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    int          cyc = 0;
    int          ren_cnt = 0;
    logic [15:0] cap_data [$];
    logic        cap_last [$];
    int          cap_cyc  [$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.fifo_ren) ren_cnt = ren_cnt + 1;
        if (bus.m_valid && bus.m_ready) begin
            cap_data.push_back(bus.m_data);
            cap_last.push_back(bus.m_last);
            cap_cyc.push_back(cyc);
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = first + 16'(i);
            wr_ptr      = wr_ptr + 1;
        end
    endtask

    task automatic wait_caps(input string tag, input int n, input int limit);
        for (int k = 0; k < limit && cap_data.size() < n; k++) tick();
        check(tag, cap_data.size(), n);
    endtask

    function automatic int gap_errors(input int base, input int n);
        int e = 0;
        for (int i = base + 1; i < base + n && i < cap_cyc.size(); i++)
            if (cap_cyc[i] - cap_cyc[i-1] != 1) e++;
        return e;
    endfunction

    int base;
    int r0;
    int seen;

    initial begin
        bus.m_ready = 1'b0;
        #2 rst = 1'b0;
        tick();
        check("rst_ren",   bus.fifo_ren, 0);
        check("rst_valid", bus.m_valid, 0);
        check("rst_last",  bus.m_last, 0);
        check("rst_data",  bus.m_data, 0);
        check("rst_total", bus.beat_total, 0);
        tick();
        rst = 1'b1;
        tick();

        // Full-rate drain of 0x0001..0x0008
        bus.m_ready = 1'b1;
        base = cap_data.size();
        load(16'h0001, 8);
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = bus.fifo_ren;
        end
        check("t2_first_ren", seen, 1);
        @(negedge clk);
        check("t2_valid_n1", bus.m_valid, 0);
        @(negedge clk);
        check("t2_valid_n2", bus.m_valid, 1);
        wait_caps("t2_count", base + 8, 40);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_data%0d", i), cap_data[base+i], 32'(i + 1));
            check($sformatf("t2_last%0d", i), cap_last[base+i], (i % 4 == 3) ? 1 : 0);
        end
        check("t2_gaps",  gap_errors(base, 8), 0);
        check("t2_total", bus.beat_total, 8);

        // Stall 10 cycles with the same load
        tick();
        bus.m_ready = 1'b0;
        r0   = ren_cnt;
        base = cap_data.size();
        load(16'h0001, 8);
        repeat (10) tick();
        check("t3_ren_stall", ren_cnt - r0, 3);
        check("t3_hold_data", bus.m_data, 16'h0001);
        check("t3_hold_valid", bus.m_valid, 1);
        bus.m_ready = 1'b1;
        wait_caps("t3_count", base + 8, 40);
        for (int i = 0; i < 8; i++)
            check($sformatf("t3_data%0d", i), cap_data[base+i], 32'(i + 1));
        check("t3_gaps",  gap_errors(base, 8), 0);
        check("t3_total", bus.beat_total, 16);

        // Alternating ready over 0x00A0..0x00AF
        tick();
        base = cap_data.size();
        load(16'h00A0, 16);
        for (int k = 0; k < 100 && cap_data.size() < base + 16; k++) begin
            bus.m_ready = (k % 2 == 0);
            tick();
        end
        check("t4_count", cap_data.size(), base + 16);
        for (int i = 0; i < 16 && base + i < cap_data.size(); i++) begin
            check($sformatf("t4_data%0d", i), cap_data[base+i], 32'h00A0 + 32'(i));
            check($sformatf("t4_last%0d", i), cap_last[base+i], (i % 4 == 3) ? 1 : 0);
        end
        check("t4_total", bus.beat_total, 32);

        // FIFO runs dry after two words; framing continues across the gap
        bus.m_ready = 1'b1;
        tick();
        r0   = ren_cnt;
        base = cap_data.size();
        load(16'h0011, 1);
        load(16'h0022, 1);
        repeat (8) tick();
        check("t5_ren_cnt", ren_cnt - r0, 2);
        check("t5_count",   cap_data.size(), base + 2);
        check("t5_valid",   bus.m_valid, 0);
        load(16'h0033, 1);
        repeat (4) tick();
        load(16'h0044, 1);
        wait_caps("t5_count2", base + 4, 20);
        check("t5_d0", cap_data[base+0], 16'h0011);
        check("t5_d1", cap_data[base+1], 16'h0022);
        check("t5_d2", cap_data[base+2], 16'h0033);
        check("t5_d3", cap_data[base+3], 16'h0044);
        check("t5_l1", cap_last[base+1], 0);
        check("t5_l2", cap_last[base+2], 0);
        check("t5_l3", cap_last[base+3], 1);
        check("t5_total", bus.beat_total, 36);

        // Async reset mid-cycle with a full buffer
        bus.m_ready = 1'b0;
        tick();
        load(16'h0055, 4);
        repeat (6) tick();
        check("t6_full_valid", bus.m_valid, 1);
        check("t6_full_ren",   bus.fifo_ren, 0);
        @(posedge clk);
        #3;
        wr_ptr = 0;
        rst    = 1'b0;
        #1;
        check("t6_rst_valid", bus.m_valid, 0);
        check("t6_rst_ren",   bus.fifo_ren, 0);
        check("t6_rst_data",  bus.m_data, 0);
        check("t6_rst_total", bus.beat_total, 0);
        tick();
        tick();
        rst = 1'b1;
        bus.m_ready = 1'b1;
        base = cap_data.size();
        load(16'h0B01, 4);
        wait_caps("t6_count", base + 4, 30);
        check("t6_d0", cap_data[base+0], 16'h0B01);
        check("t6_d3", cap_data[base+3], 16'h0B04);
        check("t6_l0", cap_last[base+0], 0);
        check("t6_l3", cap_last[base+3], 1);
        check("t6_total", bus.beat_total, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side drain engine for the team's dual-port FIFO. It watches the FIFO's `empty` flag, issues read enables, and captures the FIFO's registered read data (valid one cycle after an accepted read) into a 3-entry skid buffer. It presents the words in order on a valid/ready stream with burst framing (`m_last`). It sits in the FIFO's read-clock domain, between the FIFO and any downstream consumer that may stall.

## Interface
- `FIFO_WIDTH`, 16, word width; must equal the FIFO's width.
- `BURST_LEN`, 4, beats per burst; `m_last` marks the final beat. Legal range is 1..65535.
- `clk` input 1: single clock, rising edge. Drives the FIFO read port.
- `rst` input 1: reset, asynchronous, active-low (`rst`=0 resets).
- `fifo_empty` input 1: FIFO empty flag.
- `fifo_dout` input FIFO_WIDTH: FIFO registered read data.
- `fifo_ren` output 1: FIFO read enable.
- `m_data` output FIFO_WIDTH: stream data (head of skid buffer).
- `m_valid` output 1: stream data valid.
- `m_ready` input 1: downstream accepts the current beat.
- `m_last` output 1: current beat is the last beat of a burst.
- `beat_total` output 32: count of accepted beats since reset.

## Operation
- State: 3-entry buffer (`occ` 0..3, read/write index mod 3), `pend` flag, `beat_idx` 0..BURST_LEN-1, `beat_total`.
- Read issue: `fifo_ren` = !`fifo_empty` && (`occ` + `pend`) < 3.
  - Combinational from `fifo_empty` and registered state only. No path from `m_ready`.
  - Never asserted while `fifo_empty`=1.
- `pend` <= `fifo_ren` every cycle. When `pend`=1, `fifo_dout` holds the new word this cycle and is written into the buffer at the next edge.
- Pop: `m_valid` && `m_ready`.
  - Push and pop in the same cycle leaves `occ` unchanged.
  - Overflow cannot occur, because `occ` + `pend` ≤ 3 always.
- `m_valid` = (`occ` != 0). `m_data` = buffer[head]. Both are stable while `m_valid`=1 and `m_ready`=0.
- Order: words leave in exactly FIFO read order. No drop, no duplicate.
- Framing:
  - `m_last` = `m_valid` && (`beat_idx` == BURST_LEN-1).
  - On pop, `beat_idx` increments and wraps to 0 after BURST_LEN-1.
  - BURST_LEN=1 gives `m_last`=`m_valid` on every beat.
- `beat_total` increments on each pop and wraps from 2^32-1 to 0.
- Reset (async assert, any time, including mid-burst or with data buffered):
  - `occ`=0, `pend`=0, `beat_idx`=0, `beat_total`=0.
  - Buffer contents cleared, so `m_data`=0.
  - Outputs: `fifo_ren`=0, `m_valid`=0, `m_last`=0.
  - Reset release is synchronized to `clk` by the integrator.
  - Any read in flight when reset asserts is discarded. The FIFO is reset in the same event.

## Timing
- Latency: `fifo_ren`=1 at edge N, `fifo_dout` valid in cycle N+1, buffer write at edge N+1, `m_valid`=1 in cycle N+2. First word appears 2 cycles after `fifo_empty` falls, given `occ`=`pend`=0.
- Throughput: 1 beat/cycle sustained with `m_ready` held high and the FIFO non-empty. Steady state is `occ`=1, `pend`=1, `fifo_ren`=1.
- Backpressure with `m_ready`=0: reads continue until `occ` + `pend` = 3, then `fifo_ren`=0. After `m_ready` rises, reads resume the cycle after the first pop.
- FIFO goes empty mid-stream: `fifo_ren` drops the same cycle. Buffered words still drain at 1/cycle.
- `m_ready` may be high while `m_valid`=0; this has no effect.

## Test plan
- Reset with `rst`=0, FIFO empty -> `fifo_ren`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `beat_total`=0.
- FIFO preloaded with 0x0001..0x0008, `m_ready`=1 -> first `m_valid` 2 cycles after the first `fifo_ren`, then 8 consecutive beats 0x0001..0x0008. `m_last` on 0x0004 and 0x0008. `beat_total`=8.
- Same load, `m_ready`=0 for 10 cycles, then 1 -> exactly 3 `fifo_ren` pulses during the stall. `m_data` held at 0x0001. After release, all 8 words are in order with no gaps.
- `m_ready` toggles 1,0,1,0 with the FIFO loaded with 0x00A0..0x00AF -> all 16 words in order, no duplicates. `m_last` every 4th accepted beat.
- FIFO holds 2 words (0x0011, 0x0022), then goes empty -> `fifo_ren` asserted for exactly 2 cycles. Both words are output. `m_valid` then falls. `beat_idx`=2, so the next word 0x0033 written later is beat 3 and the word after it carries `m_last`.
- Assert `rst`=0 asynchronously mid-edge-cycle with `occ`=3 -> `m_valid`=0 and `fifo_ren`=0 immediately, before the next clock edge. After release with a refilled FIFO, the first beat has `beat_idx`=0 and `beat_total` restarts from 0.
